// File: rtl/wheel_radius_reader_if.sv
// Read port between wheel_radius_reader (master) and the wheel slot storage
// (slave). The master raises rd_req with a slot index; the slave answers
// with rd_ack and the radius of that slot.
interface wheel_radius_reader_if #(
    parameter int NUM_WHEELS = 4,
    parameter int RADIUS_W   = 2
);
    localparam int IDX_W = (NUM_WHEELS > 1) ? $clog2(NUM_WHEELS) : 1;

    logic                rd_req;
    logic [IDX_W-1:0]    rd_idx;
    logic                rd_ack;
    logic [RADIUS_W-1:0] rd_radius;

    modport master (
        output rd_req,
        output rd_idx,
        input  rd_ack,
        input  rd_radius
    );

    modport slave (
        input  rd_req,
        input  rd_idx,
        output rd_ack,
        output rd_radius
    );
endinterface

// File: rtl/wheel_radius_reader.sv
// wheel_radius_reader: sweeps every wheel slot over a req/ack read port and
// publishes a coherent snapshot (packed radii, their sum, timeout flag).
// Optional macro WHEEL_READ_TIMEOUT_EN adds a per-slot timeout counter; when
// it is undefined the sweep waits indefinitely for each ack and err stays 0.
module wheel_radius_reader #(
    parameter int  NUM_WHEELS = 4,
    parameter int  RADIUS_W   = 2,
    parameter int  TIMEOUT    = 15,
    localparam int IDX_W      = (NUM_WHEELS > 1) ? $clog2(NUM_WHEELS) : 1,
    localparam int SUM_W      = RADIUS_W + $clog2(NUM_WHEELS + 1),
    localparam int VEC_W      = NUM_WHEELS * RADIUS_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    wheel_radius_reader_if.master       rd_bus,
    output logic                        busy,
    output logic [VEC_W-1:0]            snap_radius,
    output logic [SUM_W-1:0]            snap_sum,
    output logic                        snap_valid,
    output logic                        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_rd_req;
    logic [IDX_W-1:0]   r_rd_idx;
    logic               r_busy;
    logic [VEC_W-1:0]   r_work;
    logic [SUM_W-1:0]   r_work_sum;
    logic               r_work_err;
    logic [VEC_W-1:0]   r_snap_radius;
    logic [SUM_W-1:0]   r_snap_sum;
    logic               r_snap_valid;
    logic               r_err;

    logic               w_ack;
    logic               w_timeout;
    logic               w_advance;
    logic               w_last;
    logic [RADIUS_W-1:0] w_slot_val;
    logic [VEC_W-1:0]   w_work_next;
    logic [SUM_W-1:0]   w_sum_next;
    logic               w_err_next;

    // An ack only counts while a request is outstanding.
    assign w_ack = r_rd_req & rd_bus.rd_ack;

`ifdef WHEEL_READ_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT - 1);
    logic [7:0] r_to_cnt;

    // A slot is abandoned in the TIMEOUT-th unacknowledged cycle; an ack in
    // that same cycle still wins.
    assign w_timeout = r_rd_req & ~rd_bus.rd_ack & (r_to_cnt == TO_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_advance  = w_ack | w_timeout;
    assign w_last     = (r_rd_idx == IDX_W'(NUM_WHEELS - 1));
    // Abandoned slots are recorded as radius 0.
    assign w_slot_val = w_ack ? rd_bus.rd_radius : '0;
    assign w_sum_next = r_work_sum + SUM_W'(w_slot_val);
    assign w_err_next = r_work_err | w_timeout;

    // Work vector with the current slot replaced by this cycle's value.
    generate
        for (genvar gi = 0; gi < NUM_WHEELS; gi++) begin : g_slot
            assign w_work_next[gi*RADIUS_W +: RADIUS_W] =
                (r_rd_idx == IDX_W'(gi)) ? w_slot_val
                                         : r_work[gi*RADIUS_W +: RADIUS_W];
        end
    endgenerate

    // Sweep FSM; the snapshot loads on the edge into DONE so that it and
    // snap_valid appear together during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rd_req      <= 1'b0;
            r_rd_idx      <= '0;
            r_busy        <= 1'b0;
            r_work        <= '0;
            r_work_sum    <= '0;
            r_work_err    <= 1'b0;
            r_snap_radius <= '0;
            r_snap_sum    <= '0;
            r_snap_valid  <= 1'b0;
            r_err         <= 1'b0;
`ifdef WHEEL_READ_TIMEOUT_EN
            r_to_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_snap_valid <= 1'b0;
                    if (start) begin
                        r_state    <= S_READ;
                        r_rd_req   <= 1'b1;
                        r_rd_idx   <= '0;
                        r_busy     <= 1'b1;
                        r_work_sum <= '0;
                        r_work_err <= 1'b0;
`ifdef WHEEL_READ_TIMEOUT_EN
                        r_to_cnt   <= '0;
`endif
                    end
                end
                S_READ: begin
                    if (w_advance) begin
                        r_work     <= w_work_next;
                        r_work_sum <= w_sum_next;
                        r_work_err <= w_err_next;
`ifdef WHEEL_READ_TIMEOUT_EN
                        r_to_cnt   <= '0;
`endif
                        if (w_last) begin
                            r_rd_req      <= 1'b0;
                            r_state       <= S_DONE;
                            r_snap_radius <= w_work_next;
                            r_snap_sum    <= w_sum_next;
                            r_err         <= w_err_next;
                            r_snap_valid  <= 1'b1;
                        end else begin
                            r_rd_idx <= r_rd_idx + 1'b1;
                        end
                    end else begin
`ifdef WHEEL_READ_TIMEOUT_EN
                        r_to_cnt <= r_to_cnt + 8'd1;
`endif
                    end
                end
                S_DONE: begin
                    r_snap_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_bus.rd_req = r_rd_req;
    assign rd_bus.rd_idx = r_rd_idx;
    assign busy          = r_busy;
    assign snap_radius   = r_snap_radius;
    assign snap_sum      = r_snap_sum;
    assign snap_valid    = r_snap_valid;
    assign err           = r_err;

endmodule

// File: tb/tb_wheel_radius_reader.sv
// Randomized self-checking bench for wheel_radius_reader (4 wheels, 2-bit
// radii). Expected snapshots come from a per-sweep arithmetic model of the
// radii/ack-delay tables; one line is printed per sweep.
module tb_wheel_radius_reader;

    localparam int NW      = 4;
    localparam int RW      = 2;
    localparam int TIMEOUT = 15;
`ifdef WHEEL_READ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           busy;
    logic [7:0]     snap_radius;
    logic [4:0]     snap_sum;
    logic           snap_valid;
    logic           err;

    wheel_radius_reader_if #(.NUM_WHEELS(NW), .RADIUS_W(RW)) bus ();

    wheel_radius_reader #(.NUM_WHEELS(NW), .RADIUS_W(RW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rd_bus      (bus.master),
        .busy        (busy),
        .snap_radius (snap_radius),
        .snap_sum    (snap_sum),
        .snap_valid  (snap_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the currently published snapshot.
    int model_snap = 0;
    int model_sum  = 0;
    int model_err  = 0;

    // Per-sweep stimulus tables: radius and number of idle cycles before ack.
    int radii  [NW];
    int delays [NW];
    int sweep_no = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_req"}, int'(bus.rd_req), 0);
        check({tag, "_busy"},   int'(busy), 0);
        check({tag, "_snap"},   int'(snap_radius), 0);
        check({tag, "_sum"},    int'(snap_sum), 0);
        check({tag, "_valid"},  int'(snap_valid), 0);
        check({tag, "_err"},    int'(err), 0);
    endtask

    // One sweep driven from the radii/delays tables; mid_start also pulses
    // start randomly while busy (including the DONE cycle).
    task automatic run_sweep(input bit mid_start);
        int exp_snap = 0;
        int exp_sum  = 0;
        int exp_err  = 0;
        int cycles   = 0;
        bit ack;
        for (int i = 0; i < NW; i++) begin
            if (TO_EN && delays[i] >= TIMEOUT) begin
                exp_err = 1;
            end else begin
                exp_snap += radii[i] << (RW * i);
                exp_sum  += radii[i];
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            for (int k = 0; k < 64; k++) begin
                check("rd_req",    int'(bus.rd_req), 1);
                check("rd_idx",    int'(bus.rd_idx), i);
                check("busy",      int'(busy), 1);
                check("valid_lo",  int'(snap_valid), 0);
                check("snap_hold", int'(snap_radius), model_snap);
                check("sum_hold",  int'(snap_sum), model_sum);
                if (mid_start) start = 1'($urandom);
                ack = (k == delays[i]);
                bus.rd_ack    = ack;
                bus.rd_radius = ack ? 2'(radii[i]) : 2'($urandom);
                @(posedge clk); #1;
                cycles++;
                if (ack) break;
                if (TO_EN && k == TIMEOUT - 1) break;
            end
        end
        bus.rd_ack = 1'($urandom);
        start      = mid_start;
        check("done_valid", int'(snap_valid), 1);
        check("done_rd_req", int'(bus.rd_req), 0);
        check("done_busy",  int'(busy), 1);
        check("snap_radius", int'(snap_radius), exp_snap);
        check("snap_sum",   int'(snap_sum), exp_sum);
        check("err",        int'(err), exp_err);
        model_snap = exp_snap;
        model_sum  = exp_sum;
        model_err  = exp_err;
        @(posedge clk); #1;
        start      = 1'b0;
        bus.rd_ack = 1'b0;
        check("post_valid", int'(snap_valid), 0);
        check("post_busy",  int'(busy), 0);
        check("post_rd_req", int'(bus.rd_req), 0);
        check("post_snap",  int'(snap_radius), model_snap);
        sweep_no++;
        $display("sweep %0d: radii=%0d,%0d,%0d,%0d delays=%0d,%0d,%0d,%0d read cycles=%0d snap=%02h sum=%0d err=%0d",
                 sweep_no, radii[0], radii[1], radii[2], radii[3],
                 delays[0], delays[1], delays[2], delays[3], cycles,
                 exp_snap, exp_sum, exp_err);
    endtask

    task automatic set_tables(input int r0, r1, r2, r3, input int d0, d1, d2, d3);
        radii[0] = r0;  radii[1] = r1;  radii[2] = r2;  radii[3] = r3;
        delays[0] = d0; delays[1] = d1; delays[2] = d2; delays[3] = d3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_ack    = 1'b0;
        bus.rd_radius = '0;

        // Reset state while rst_n is held low.
        #2;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle: stray acks must not start anything.
        for (int c = 0; c < 20; c++) begin
            bus.rd_ack    = 1'($urandom);
            bus.rd_radius = 2'($urandom);
            @(posedge clk); #1;
            check("idle_rd_req", int'(bus.rd_req), 0);
            check("idle_busy",   int'(busy), 0);
            check("idle_valid",  int'(snap_valid), 0);
            check("idle_snap",   int'(snap_radius), 0);
        end
        bus.rd_ack = 1'b0;

        // Car: ack every cycle, radius 3 -> FF / 12.
        set_tables(3, 3, 3, 3, 0, 0, 0, 0);
        run_sweep(1'b0);
        // Slow acks, radius 1.
        set_tables(1, 1, 1, 1, 3, 3, 3, 3);
        run_sweep(1'b0);
        // Mixed radii -> E4 / 6.
        set_tables(0, 1, 2, 3, 0, 0, 0, 0);
        run_sweep(1'b0);
        // Second sweep keeps E4 visible until its own DONE; start spam ignored.
        set_tables(3, 3, 3, 3, 2, 1, 4, 0);
        run_sweep(1'b1);

        if (TO_EN) begin
            set_tables(3, 3, 0, 3, 0, 0, 40, 0);
            run_sweep(1'b0);
            set_tables(3, 3, 3, 3, 0, 0, 0, 0);
            run_sweep(1'b0);
            set_tables(2, 1, 3, 0, 1, 0, TIMEOUT - 1, 0);
            run_sweep(1'b0);
        end

        // Asynchronous reset while slot 2 is being read.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.rd_ack    = 1'b1;
        bus.rd_radius = 2'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.rd_ack = 1'b0;
        check("abort_idx", int'(bus.rd_idx), 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_snap = 0;
        model_sum  = 0;
        model_err  = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_tables(2, 0, 3, 1, 0, 1, 0, 2);
        run_sweep(1'b0);

        // Randomized sweeps.
        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < NW; i++) begin
                radii[i]  = int'($urandom_range(0, 3));
                delays[i] = int'($urandom_range(0, 4));
                if (TO_EN && $urandom_range(0, 5) == 0) delays[i] = TIMEOUT + 3;
            end
            run_sweep(1'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
